blake2_g_pipe: RTL

- Parametrised successor to the fixed BLAKE2b G-function core.
- Computes one BLAKE2 G mixing function per accepted input. Word width and rotation constants are selectable, so one block serves BLAKE2b (64-bit) and BLAKE2s (32-bit).
- Adds a configurable register pipeline with valid/ready handshake, backpressure stall and a user tag carried alongside the data.
- Sits below the round/compression controller; several instances form a column/diagonal round.

---
 rtl/blake2_g_pipe.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/blake2_g_pipe.sv
// blake2_g_pipe: BLAKE2 G mixing function with a configurable register pipeline.
//   One G evaluation per accepted input. W selects BLAKE2b (64) or BLAKE2s (32)
//   rotation constants. PIPELINES (0..4) register stages split the eight G steps
//   into near-equal slices, and each slice is followed by its register. All
//   stages share one enable, so the pipeline stalls as a whole under
//   backpressure and bubbles stay where they are.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_a..i_d, i_m0, i_m1    G state words and message words (W bits)
//   i_tag                   sideband tag, returned unchanged with the result
//   i_val / o_rdy           input handshake
//   o_a..o_d, o_tag         result words and the tag of the current output
//   o_val / i_rdy           output handshake
module blake2_g_pipe #(
  parameter int unsigned W         = 64,
  parameter int unsigned PIPELINES = 1,
  parameter int unsigned TAG_W     = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [W-1:0]     i_a,
  input  logic [W-1:0]     i_b,
  input  logic [W-1:0]     i_c,
  input  logic [W-1:0]     i_d,
  input  logic [W-1:0]     i_m0,
  input  logic [W-1:0]     i_m1,
  input  logic [TAG_W-1:0] i_tag,
  input  logic             i_val,
  output logic             o_rdy,
  output logic [W-1:0]     o_a,
  output logic [W-1:0]     o_b,
  output logic [W-1:0]     o_c,
  output logic [W-1:0]     o_d,
  output logic [TAG_W-1:0] o_tag,
  output logic             o_val,
  input  logic             i_rdy
);

  localparam int unsigned NSTEP = 8;
  localparam int unsigned R1    = (W == 64) ? 32 : 16;
  localparam int unsigned R2    = (W == 64) ? 24 : 12;
  localparam int unsigned R3    = (W == 64) ? 16 : 8;
  localparam int unsigned R4    = (W == 64) ? 63 : 7;
  localparam int unsigned NS    = (PIPELINES == 0) ? 1 : PIPELINES;

  // Elaboration-time parameter legality
  if (W != 64 && W != 32) begin : g_bad_w
    $fatal(1, "blake2_g_pipe: W must be 32 or 64");
  end
  if (PIPELINES > 4) begin : g_bad_p
    $fatal(1, "blake2_g_pipe: PIPELINES must be 0..4");
  end

  // Rotate right by a constant amount
  function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned r);
    return (x >> r) | (x << (W - r));
  endfunction

  // Apply G steps [first, last) to the packed {a,b,c,d} state.
  // Step 0 consumes m0 and step 4 consumes m1.
  function automatic logic [4*W-1:0] g_slice(
    input logic [4*W-1:0] st,
    input logic [W-1:0]   m0,
    input logic [W-1:0]   m1,
    input int unsigned    first,
    input int unsigned    last
  );
    logic [W-1:0] a, b, c, d;
    {a, b, c, d} = st;
    for (int unsigned k = 0; k < NSTEP; k++) begin
      if (k >= first && k < last) begin
        case (k)
          0:       a = a + b + m0;
          1:       d = rotr(d ^ a, R1);
          2:       c = c + d;
          3:       b = rotr(b ^ c, R2);
          4:       a = a + b + m1;
          5:       d = rotr(d ^ a, R3);
          6:       c = c + d;
          default: b = rotr(b ^ c, R4);
        endcase
      end
    end
    return {a, b, c, d};
  endfunction

  if (PIPELINES == 0) begin : g_comb
    // Pure combinational path; clock and reset have no function here
    logic unused_clk_rst;
    assign unused_clk_rst        = i_clk ^ i_rst;
    assign {o_a, o_b, o_c, o_d}  = g_slice({i_a, i_b, i_c, i_d}, i_m0, i_m1, 0, NSTEP);
    assign o_tag                 = i_tag;
    assign o_val                 = i_val;
    assign o_rdy                 = i_rdy;
  end else begin : g_pipe
    localparam int unsigned LAST_S = PIPELINES - 1;

    logic [4*W-1:0]   st_q  [NS];
    logic [W-1:0]     m1_q  [NS];
    logic [TAG_W-1:0] tag_q [NS];
    logic             val_q [NS];
    logic             en;

    // Global advance: move when the output slot is free or being taken
    assign en    = i_rdy || !o_val;
    assign o_rdy = en;

    for (genvar s = 0; s < PIPELINES; s++) begin : g_stage
      // Slice boundaries: ceil(8*s/P) .. ceil(8*(s+1)/P)
      localparam int unsigned FIRST = (NSTEP * 32'(s) + PIPELINES - 1) / PIPELINES;
      localparam int unsigned LAST  = (NSTEP * 32'(s + 1) + PIPELINES - 1) / PIPELINES;

      logic [4*W-1:0]   src_st;
      logic [W-1:0]     src_m0;
      logic [W-1:0]     src_m1;
      logic [TAG_W-1:0] src_tag;
      logic             src_val;

      if (s == 0) begin : g_head
        assign src_st  = {i_a, i_b, i_c, i_d};
        assign src_m0  = i_m0;
        assign src_m1  = i_m1;
        assign src_tag = i_tag;
        assign src_val = i_val;
      end else begin : g_link
        // m0 is always consumed by step 0, which lives in the first slice
        assign src_st  = st_q[s-1];
        assign src_m0  = '0;
        assign src_m1  = m1_q[s-1];
        assign src_tag = tag_q[s-1];
        assign src_val = val_q[s-1];
      end

      // Stage register: data and valid clear on reset, hold while stalled
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          st_q[s]  <= '0;
          m1_q[s]  <= '0;
          tag_q[s] <= '0;
          val_q[s] <= 1'b0;
        end else if (en) begin
          st_q[s]  <= g_slice(src_st, src_m0, src_m1, FIRST, LAST);
          m1_q[s]  <= (LAST <= NSTEP / 2) ? src_m1 : '0;
          tag_q[s] <= src_tag;
          val_q[s] <= src_val;
        end
      end
    end

    assign {o_a, o_b, o_c, o_d} = st_q[LAST_S];
    assign o_tag                = tag_q[LAST_S];
    assign o_val                = val_q[LAST_S];
  end

endmodule
